// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: one state per cycle, Moore decode of state + latched instr.
// Drives every datapath select/enable and reports retire (instr_done) and illegal-opcode (trap).
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               carry,
  input  logic               sign,
  input  logic               overflow,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [3:0]         alu_control,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               trap
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_JAL       = 4'd9,
    S_JALR      = 4'd10,
    S_JALR_LINK = 4'd11,
    S_BRANCH    = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  state_e      r_state;
  state_e      w_state_next;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic [3:0]  w_alu_op;
  logic        w_take;
  logic        w_unused_instr_bits;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_funct7b5 = instr[30];
  assign w_unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign state = STATE_W'(r_state);
  assign trap  = (r_state == S_TRAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECR;
          OP_ITYPE:          w_state_next = S_EXECI;
          OP_JAL:            w_state_next = S_JAL;
          OP_JALR:           w_state_next = S_JALR;
          OP_BRANCH:         w_state_next = S_BRANCH;
          OP_LUI:            w_state_next = S_LUI;
          OP_AUIPC:          w_state_next = S_AUIPC;
          default:           w_state_next = S_TRAP;
        endcase
      end
      S_MEMADR:    w_state_next = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   w_state_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL, S_JALR_LINK, S_LUI, S_AUIPC:
                   w_state_next = S_ALUWB;
      S_JALR:      w_state_next = S_JALR_LINK;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH:
                   w_state_next = S_FETCH;
      S_TRAP:      w_state_next = S_TRAP;
      default:     w_state_next = S_FETCH;
    endcase
  end

  // Shared R/I op table; only R-type lets funct7b5 turn ADD into SUB.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_funct3)
      3'b000: w_alu_op = ((r_state == S_EXECR) && w_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_op = ALU_SLL;
      3'b010: w_alu_op = ALU_SLT;
      3'b011: w_alu_op = ALU_SLTU;
      3'b100: w_alu_op = ALU_XOR;
      3'b101: w_alu_op = w_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_op = ALU_OR;
      3'b111: w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_funct3)
      3'b000: w_take = zero;
      3'b001: w_take = ~zero;
      3'b100: w_take = sign ^ overflow;
      3'b101: w_take = ~(sign ^ overflow);
      3'b110: w_take = ~carry;
      3'b111: w_take = carry;
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    instr_done  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (w_opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = w_alu_op;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = w_alu_op;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = w_take;
        instr_done  = 1'b1;
      end
      S_LUI: begin
        alu_src_b   = 2'b01;
        imm_src     = IMM_U;
        alu_control = ALU_PASSB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected output sequences built from
// the instruction class, compared every cycle, plus reset/trap scenarios and random instructions.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       done;
    logic       trap;
  } out_t;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4;
  localparam logic [3:0] SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9, PASSB = 4'd10;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero, carry, sign, overflow;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic [3:0]  state;
  logic        instr_done, trap;
  out_t        got;

  int   n_checks = 0;
  int   n_err    = 0;
  out_t exp_q[$];

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .zero(zero), .carry(carry), .sign(sign), .overflow(overflow),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .state(state), .instr_done(instr_done), .trap(trap)
  );

  assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, instr_done, trap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t st(input logic pcw, input logic adr, input logic mw,
                              input logic irw, input logic rw, input logic [1:0] rs,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [2:0] imm, input logic [3:0] alu, input logic done);
    out_t o;
    o.pc_write = pcw; o.adr_src = adr; o.mem_write = mw; o.ir_write = irw;
    o.reg_write = rw; o.result_src = rs; o.src_a = a; o.src_b = b;
    o.imm = imm; o.alu = alu; o.done = done; o.trap = 1'b0;
    return o;
  endfunction

  function automatic out_t fetch_out();
    return st(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 3'd0, ADD, 1'b0);
  endfunction

  function automatic out_t writeback_out();
    return st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b1);
  endfunction

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'd0: return (is_r && f7) ? SUB : ADD;
      3'd1: return SLL;
      3'd2: return SLT;
      3'd3: return SLTU;
      3'd4: return XOR_;
      3'd5: return f7 ? SRA : SRL;
      3'd6: return OR_;
      default: return AND_;
    endcase
  endfunction

  // Branch outcome from the comparison each funct3 asks for, expressed via the ALU flags of rd1-rd2.
  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic c,
                                        input logic s, input logic v);
    logic eq, lt, ltu;
    eq  = z;
    lt  = (s != v);
    ltu = !c;
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void build(input logic [31:0] ins, input logic z, input logic c,
                                input logic s, input logic v);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    out_t       t;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[30];
    exp_q.delete();
    exp_q.push_back(fetch_out());
    exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1,
                       (op == 7'b1101111) ? 3'd3 : 3'd2, ADD, 1'b0));
    case (op)
      7'b0000011: begin
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, ADD, 1'b0));
        exp_q.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b0));
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 3'd0, ADD, 1'b1));
      end
      7'b0100011: begin
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd1, ADD, 1'b0));
        exp_q.push_back(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, ADD, 1'b1));
      end
      7'b0110011: begin
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 3'd0,
                           arith_op(f3, f7, 1'b1), 1'b0));
        exp_q.push_back(writeback_out());
      end
      7'b0010011: begin
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0,
                           arith_op(f3, f7, 1'b0), 1'b0));
        exp_q.push_back(writeback_out());
      end
      7'b1101111: begin
        exp_q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, ADD, 1'b0));
        exp_q.push_back(writeback_out());
      end
      7'b1100111: begin
        exp_q.push_back(st(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 2'd1, 3'd0, ADD, 1'b0));
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 3'd0, ADD, 1'b0));
        exp_q.push_back(writeback_out());
      end
      7'b1100011: begin
        exp_q.push_back(st(branch_taken(f3, z, c, s, v), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0,
                           2'd2, 2'd0, 3'd0, SUB, 1'b1));
      end
      7'b0110111: begin
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 3'd4, PASSB, 1'b0));
        exp_q.push_back(writeback_out());
      end
      7'b0010111: begin
        exp_q.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 3'd4, ADD, 1'b0));
        exp_q.push_back(writeback_out());
      end
      default: begin
        t = '0;
        t.trap = 1'b1;
        for (int k = 0; k < 20; k++) exp_q.push_back(t);
      end
    endcase
  endfunction

  // Entered at a falling edge with the DUT in FETCH; leaves at the next FETCH's falling edge,
  // or mid-cycle right after step stop_at when stop_at >= 0.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic z,
                           input logic c, input logic s, input logic v, input int stop_at);
    build(ins, z, c, s, v);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      else begin
        instr = ins; zero = z; carry = c; sign = s; overflow = v;
      end
      #1;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s step %0d: outputs got %h expected %h", name, i, got, exp_q[i]);
      end
      n_checks++;
      if ((i == 0) ? (state !== 4'd0) : (state === 4'd0 || $isunknown(state))) begin
        n_err++;
        $display("FAIL %s step %0d state: got %0d expected %s", name, i, state,
                 (i == 0) ? "0" : "nonzero");
      end
      if (i == stop_at) begin
        $display("instr %s %h: stopped after %0d cycles", name, ins, i + 1);
        return;
      end
    end
    @(negedge clk);
    $display("instr %s %h: %0d cycles", name, ins, exp_q.size());
  endtask

  task automatic check_fetch_after_reset(input string name);
    n_checks++;
    if (state !== 4'd0) begin n_err++; $display("FAIL %s state: got %0d expected 0", name, state); end
    n_checks++;
    if (ir_write !== 1'b1) begin n_err++; $display("FAIL %s ir_write: got %b expected 1", name, ir_write); end
    n_checks++;
    if (pc_write !== 1'b1) begin n_err++; $display("FAIL %s pc_write: got %b expected 1", name, pc_write); end
    n_checks++;
    if (trap !== 1'b0) begin n_err++; $display("FAIL %s trap: got %b expected 0", name, trap); end
  endtask

  task automatic test_reset();
    reset = 1'b0; instr = 32'h0; zero = 1'b0; carry = 1'b0; sign = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_fetch_after_reset("reset");
    n_checks++;
    if (got !== fetch_out()) begin
      n_err++;
      $display("FAIL reset outputs: got %h expected %h", got, fetch_out());
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_alu_ops();
    run_instr("add", 32'h00B50533, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("sub", 32'h40B50533, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("srai", 32'h40B55513, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("lui", 32'h123452B7, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("jalr", 32'h000500E7, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_load_store();
    run_instr("lw", 32'h0000A503, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("sw", 32'h00B52223, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h00B50463, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_instr("beq_not", 32'h00B50463, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_instr("bltu_taken", 32'h00B56463, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_instr("bltu_not", 32'h00B56463, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_instr("blt_taken", 32'h00B54463, 1'b0, 1'b1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_memread();
    run_instr("lw_abort", 32'h0000A503, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    reset = 1'b0;
    #1;
    check_fetch_after_reset("abort_reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_fetch_after_reset("abort_release");
    run_instr("add_after_abort", 32'h00B50533, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_trap();
    run_instr("illegal", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 21);
    reset = 1'b0;
    #1;
    check_fetch_after_reset("trap_reset");
    @(negedge clk);
    reset = 1'b1;
    run_instr("add_after_trap", 32'h00B50533, 1'b0, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 8)];
      run_instr("random", ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_reset_mid_memread();
    test_trap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
